fifo_wr_packer: RTL and testbench



---
 rtl/fifo_wr_packer.sv | 185 ++++++++++++++++++
 tb/tb_fifo_wr_packer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: write-side front end of the asymmetric-width FIFO.
// Packs pairs of narrow words into one wide word (first word = low half),
// drives the memory write port, owns the write pointer, synchronises the
// read pointer into wclk_int and derives full / occupancy status.
// Optional almost-full output is enabled by defining FIFO_WR_PACKER_AFULL_EN.
module fifo_wr_packer #(
  parameter int                RAM_RW            = 18,
  parameter int                RAM_WW            = 36,
  parameter int                RAM_WD            = 10,
  parameter int                RAM_RD            = 11,
  parameter int                WRITE_ADDRESS_END = 1024,
  parameter logic [RAM_RW-1:0] PAD_VALUE         = '0
`ifdef FIFO_WR_PACKER_AFULL_EN
  ,
  parameter int                AFULL_THRESH      = 4
`endif
) (
  input  logic              wclk_int,
  input  logic              rst_int,
  input  logic [RAM_RW-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              flush,
  input  logic [RAM_RD:0]   rptr_gray,
  output logic              we,
  output logic [RAM_WD-1:0] waddr,
  output logic [RAM_WW-1:0] data,
  output logic [RAM_WD:0]   wptr_gray,
  output logic              full,
  output logic              partial,
  output logic [RAM_WD:0]   wr_count
`ifdef FIFO_WR_PACKER_AFULL_EN
  ,
  output logic              afull
`endif
);

  localparam logic [RAM_WD:0] DEPTH = (RAM_WD+1)'(WRITE_ADDRESS_END);

  typedef enum logic {
    S_LO,
    S_HI
  } state_t;

  function automatic logic [RAM_RD:0] gray2bin(input logic [RAM_RD:0] g);
    logic [RAM_RD:0] b;
    b = '0;
    for (int unsigned i = 0; i <= RAM_RD; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  state_t              state_q, state_d;
  logic [RAM_RW-1:0]   lo_q, lo_d;
  logic                we_q, we_d;
  logic [RAM_WD-1:0]   waddr_q, waddr_d;
  logic [RAM_WW-1:0]   data_q, data_d;
  logic [RAM_WD:0]     wptr_q, wptr_d;
  logic [RAM_WD:0]     wptr_gray_q, wptr_gray_d;
  logic [RAM_RD:0]     rsync1_q, rsync2_q;

  logic [RAM_RD:0]     rptr_b;
  logic [RAM_WD:0]     freed;
  logic [RAM_WD:0]     count_w;
  logic                full_w;
  logic                ready_w;
  logic                unused_rptr_lsb;

  // Read pointer in wide units: a slot is free only once both halves are read.
  always_comb begin
    rptr_b          = gray2bin(rsync2_q);
    freed           = rptr_b[RAM_RD:1];
    unused_rptr_lsb = rptr_b[0];
    count_w         = wptr_q - freed;
    full_w          = (count_w == DEPTH);
  end

  // Packing FSM: next state, pending write and pointer advance.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    data_d  = data_q;
    wptr_d  = wptr_q;
    ready_w = 1'b1;
    unique case (state_q)
      S_LO: begin
        ready_w = 1'b1;
        if (din_valid) begin
          lo_d    = din;
          state_d = S_HI;
        end
      end
      S_HI: begin
        ready_w = ~full_w;
        if (!full_w && din_valid) begin
          we_d    = 1'b1;
          waddr_d = wptr_q[RAM_WD-1:0];
          data_d  = {din, lo_q};
          wptr_d  = wptr_q + 1'b1;
          state_d = S_LO;
        end else if (!full_w && flush) begin
          we_d    = 1'b1;
          waddr_d = wptr_q[RAM_WD-1:0];
          data_d  = {PAD_VALUE, lo_q};
          wptr_d  = wptr_q + 1'b1;
          state_d = S_LO;
        end
      end
      default: state_d = S_LO;
    endcase
    wptr_gray_d = wptr_d ^ (wptr_d >> 1);
  end

  // State, held low half, write port and write pointer registers.
  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      state_q     <= S_LO;
      lo_q        <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      data_q      <= '0;
      wptr_q      <= '0;
      wptr_gray_q <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      data_q      <= data_d;
      wptr_q      <= wptr_d;
      wptr_gray_q <= wptr_gray_d;
    end
  end

  // Two-flop synchroniser for the Gray-coded read pointer.
  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      rsync1_q <= '0;
      rsync2_q <= '0;
    end else begin
      rsync1_q <= rptr_gray;
      rsync2_q <= rsync1_q;
    end
  end

`ifdef FIFO_WR_PACKER_AFULL_EN
  logic [RAM_RD:0] rptr_b_d;
  logic [RAM_WD:0] count_d;
  logic            afull_d;
  logic            afull_q;
  logic            unused_rptr_d_lsb;

  // Almost-full uses post-edge pointer values so it moves together with full.
  always_comb begin
    rptr_b_d          = gray2bin(rsync1_q);
    unused_rptr_d_lsb = rptr_b_d[0];
    count_d           = wptr_d - rptr_b_d[RAM_RD:1];
    afull_d           = ((DEPTH - count_d) <= (RAM_WD+1)'(AFULL_THRESH));
  end

  // Almost-full register.
  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign afull = afull_q;
`endif

  assign din_ready = ready_w;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign data      = data_q;
  assign wptr_gray = wptr_gray_q;
  assign full      = full_w;
  assign partial   = (state_q == S_HI);
  assign wr_count  = count_w;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Self-checking bench for fifo_wr_packer: a behavioural model (pair packing,
// integer write/read counters, two-edge read-pointer delay) is compared with
// the DUT every cycle, plus directed literal expectations.
module tb_fifo_wr_packer;
  localparam int RW    = 18;
  localparam int WW    = 36;
  localparam int WD    = 10;
  localparam int RD    = 11;
  localparam int DEPTH = 1024;
  localparam logic [RW-1:0] PAD = '0;

  logic          wclk_int = 1'b0;
  logic          rst_int  = 1'b0;
  logic [RW-1:0] din       = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          flush     = 1'b0;
  logic [RD:0]   rptr_gray;
  logic          we;
  logic [WD-1:0] waddr;
  logic [WW-1:0] data;
  logic [WD:0]   wptr_gray;
  logic          full;
  logic          partial;
  logic [WD:0]   wr_count;
`ifdef FIFO_WR_PACKER_AFULL_EN
  logic          afull;
`endif

  fifo_wr_packer #(
    .RAM_RW(RW), .RAM_WW(WW), .RAM_WD(WD), .RAM_RD(RD),
    .WRITE_ADDRESS_END(DEPTH), .PAD_VALUE(PAD)
  ) dut (
    .wclk_int(wclk_int), .rst_int(rst_int), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .flush(flush), .rptr_gray(rptr_gray), .we(we),
    .waddr(waddr), .data(data), .wptr_gray(wptr_gray), .full(full),
    .partial(partial), .wr_count(wr_count)
`ifdef FIFO_WR_PACKER_AFULL_EN
    , .afull(afull)
`endif
  );

  always #5 wclk_int = ~wclk_int;

  // Reader side: total narrow words read, presented Gray coded.
  int          r_total = 0;
  logic [RD:0] rbin;
  assign rbin      = r_total[RD:0];
  assign rptr_gray = rbin ^ (rbin >> 1);

  int checks = 0;
  int errors = 0;

  // Model state
  bit            m_hi;
  logic [RW-1:0] m_lo;
  int            m_wcount;
  bit            m_we;
  logic [WD-1:0] m_waddr;
  logic [WW-1:0] m_data;
  int            rb_d1, rb_d2;

  // Samples of the DUT taken at the compare point
  logic          s_we, s_full, s_partial, s_ready;
  logic [WD-1:0] s_waddr;
  logic [WW-1:0] s_data;
  logic [WD:0]   s_wr_count, s_wptr_gray;
`ifdef FIFO_WR_PACKER_AFULL_EN
  logic          s_afull;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = '0; m_wcount = 0; m_we = 0; m_waddr = '0; m_data = '0;
    rb_d1 = 0; rb_d2 = 0;
  endtask

  task automatic compare_all();
    int ew;
    bit ef;
    int wv;
    s_we = we; s_full = full; s_partial = partial; s_ready = din_ready;
    s_waddr = waddr; s_data = data; s_wr_count = wr_count; s_wptr_gray = wptr_gray;
    ew = m_wcount - rb_d2 / 2;
    ef = (ew == DEPTH);
    wv = m_wcount % 2048;
    chk("we", we, m_we);
    if (m_we) begin
      chk("waddr", waddr, m_waddr);
      chk("data", data, m_data);
    end
    chk("wptr_gray", wptr_gray, wv ^ (wv >> 1));
    chk("wr_count", wr_count, ew);
    chk("full", full, ef);
    chk("partial", partial, m_hi);
    chk("din_ready", din_ready, (!m_hi || !ef));
`ifdef FIFO_WR_PACKER_AFULL_EN
    s_afull = afull;
    chk("afull", afull, ((DEPTH - ew) <= 4));
`endif
  endtask

  task automatic model_step();
    int ew;
    bit ef;
    if (!rst_int) begin
      model_reset();
      return;
    end
    ew = m_wcount - rb_d2 / 2;
    ef = (ew == DEPTH);
    m_we = 0;
    if (!m_hi) begin
      if (din_valid) begin
        m_lo = din;
        m_hi = 1;
      end
    end else if (!ef && (din_valid || flush)) begin
      m_we     = 1;
      m_waddr  = WD'(m_wcount % DEPTH);
      m_data   = din_valid ? {din, m_lo} : {PAD, m_lo};
      m_wcount = m_wcount + 1;
      m_hi     = 0;
    end
    rb_d2 = rb_d1;
    rb_d1 = r_total;
  endtask

  // One clock: compare on the falling edge, advance model, return 1ns past rise.
  task automatic tick();
    @(negedge wclk_int);
    compare_all();
    model_step();
    @(posedge wclk_int);
    #1;
  endtask

  task automatic apply_reset();
    din_valid = 0; flush = 0; r_total = 0;
    rst_int = 0;
    model_reset();
    tick();
    rst_int = 1;
  endtask

  initial begin
    int nw, drop, got, lim, speed, adv;
    logic [RW-1:0] first_lo, held;
    logic [WD-1:0] wa;
    logic [WW-1:0] wdat;

    model_reset();
    tick();
    chk("rst_we", s_we, 0);
    chk("rst_waddr", s_waddr, 0);
    chk("rst_data", s_data, 0);
    chk("rst_wptr_gray", s_wptr_gray, 0);
    chk("rst_full", s_full, 0);
    chk("rst_partial", s_partial, 0);
    chk("rst_wr_count", s_wr_count, 0);
    chk("rst_din_ready", s_ready, 1);
    rst_int = 1;

    // Basic pair
    din = 18'h00001; din_valid = 1; tick();
    din = 18'h00002; tick();
    din_valid = 0; tick();
    chk("t1_we", s_we, 1);
    chk("t1_waddr", s_waddr, 0);
    chk("t1_data", s_data, 36'h000080001);
    chk("t1_wptr_gray", s_wptr_gray, 1);
    chk("t1_wr_count", s_wr_count, 1);
    chk("t1_partial", s_partial, 0);

    // Fill to full with the reader stopped
    apply_reset();
    nw = 0;
    for (int i = 0; i < 2048; i++) begin
      din = RW'($urandom); din_valid = 1; tick();
      if (s_we) nw++;
    end
    din_valid = 0; tick();
    if (s_we) nw++;
    chk("t2_writes", nw, 1024);
    chk("t2_last_waddr", s_waddr, 1023);
    chk("t2_full", s_full, 1);
    first_lo = RW'($urandom);
    din = first_lo; din_valid = 1; tick();
    held = RW'($urandom);
    din = held; tick();
    chk("t2_partial", s_partial, 1);
    chk("t2_stall_ready", s_ready, 0);
    tick();
    chk("t2_no_we", s_we, 0);

    // Reader frees one wide slot; the stalled high half completes
    r_total = 2;
    drop = 0; got = 0; wa = '1; wdat = '0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (!s_full && drop == 0) drop = k;
      if (s_we) begin
        got = 1; wa = s_waddr; wdat = s_data;
        chk("t3_wr_count", s_wr_count, 1024);
        break;
      end
    end
    din_valid = 0;
    chk("t3_full_drop_within_3", (drop > 0 && drop <= 3), 1);
    chk("t3_write_seen", got, 1);
    chk("t3_waddr", wa, 0);
    chk("t3_data", wdat, {held, first_lo});

    // Random traffic with alternating reader speed, crossing pointer wrap
    for (int cyc = 0; cyc < 13500; cyc++) begin
      speed = ((cyc % 4500) < 1500) ? 3 : 0;
      din       = RW'($urandom);
      din_valid = ($urandom % 10) < 7;
      flush     = ($urandom % 8) == 0;
      if (speed > 0) begin
        adv = $urandom_range(0, speed * 2);
        lim = 2 * m_wcount;
        r_total = (r_total + adv > lim) ? lim : r_total + adv;
      end
      tick();
    end

    // Flush
    din_valid = 0; flush = 0;
    r_total = 2 * m_wcount;
    repeat (4) tick();
    flush = 1; tick();
    flush = 0;
    r_total = 2 * m_wcount;
    repeat (4) tick();
    chk("t4_empty", s_wr_count, 0);
    din = 18'h3ABCD; din_valid = 1; tick();
    din_valid = 0; flush = 1; tick();
    flush = 0; tick();
    chk("t4_flush_we", s_we, 1);
    chk("t4_flush_data", s_data, 36'h00003ABCD);
    flush = 1; tick();
    tick();
    chk("t4_flush_lo_no_we", s_we, 0);
    flush = 0;

    // Reset with a held low half
    din = RW'($urandom); din_valid = 1; tick();
    din_valid = 0; tick();
    chk("t5_partial_before", s_partial, 1);
    apply_reset();
    nw = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (s_we) nw++;
    end
    chk("t5_no_we", nw, 0);
    chk("t5_partial", s_partial, 0);
    din = 18'h12345; din_valid = 1; tick();
    din = 18'h2AAAA; tick();
    din_valid = 0; tick();
    chk("t5_we", s_we, 1);
    chk("t5_waddr", s_waddr, 0);
    chk("t5_data", s_data, {18'h2AAAA, 18'h12345});

`ifdef FIFO_WR_PACKER_AFULL_EN
    // Almost full rises at 1020 occupied and holds through full
    apply_reset();
    got = 0; wa = '0;
    for (int i = 0; i < 2050; i++) begin
      din = RW'($urandom); din_valid = 1; tick();
      if (s_afull && !got) begin
        got = 1;
        chk("t6_afull_rise_count", s_wr_count, 1020);
      end
    end
    din_valid = 0; tick();
    chk("t6_afull_seen", got, 1);
    chk("t6_full", s_full, 1);
    chk("t6_afull_at_full", s_afull, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
